regfile_dump: RTL
=================

# regfile_dump

- Hardware register-dump sequencer; replaces the bench-side peek loop over `rf.regs[0..31]`.
- On a start pulse it stalls the CPU, walks every architectural register through a spare register-file read port, and streams each `{index, value}` out over a valid/ready interface.
- Sits beside `cpu`, sharing the register-file read port and the global stall input. Consumers are a UART/debug bridge or a bench scoreboard.

## Interface

Parameters:
- `NUM_REGS`, 32: number of registers walked, indices 0..NUM_REGS-1.
- `DATA_W`, 32: register width.
- `IDX_W`, 5: index width, $clog2(NUM_REGS).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: dump request, sampled only in IDLE.
- `cpu_stall` out 1: freezes PC and register-file writes while high.
- `rf_raddr` out IDX_W: debug read address into the register file.
- `rf_rdata` in DATA_W: combinational read data for `rf_raddr`, same cycle.
- `dump_valid` out 1: output word valid.
- `dump_ready` in 1: consumer accepts the word.
- `dump_index` out IDX_W: register index of the current word.
- `dump_data` out DATA_W: register value.
- `dump_last` out 1: high with the word for index NUM_REGS-1.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation

- FSM states: IDLE, STALL, READ, SEND, DONE.
- IDLE:
  - `start`=1 goes to STALL, clears index counter `idx` to 0.
  - `start` in any other state is ignored; it is not queued.
- STALL: lasts one cycle so an in-flight writeback commits, then goes to READ.
- READ:
  - `rf_raddr`=`idx`.
  - Captures `rf_rdata` into the `dump_data` register and `idx` into `dump_index`.
  - Sets `dump_last`=(idx==NUM_REGS-1).
  - Goes to SEND.
- SEND:
  - `dump_valid`=1.
  - `dump_data`, `dump_index` and `dump_last` stay stable until the handshake; `dump_valid` never drops without `dump_ready`.
  - On `dump_valid & dump_ready`: if `dump_last`, go to DONE; else `idx`+1 and go to READ.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `cpu_stall` is high in STALL, READ, SEND and DONE, and low in IDLE.
- `rf_raddr` always mirrors `idx`.
- Register 0 is dumped as whatever the register file returns (0). It is not special-cased.
- `idx` stops at NUM_REGS-1; there is no wrap-around.

## Timing

- Reset (`rst_n`=0 at an edge) forces: state IDLE, `idx`=0, `rf_raddr`=0, `dump_index`=0, `dump_data`=0, `dump_valid`=0, `dump_last`=0, `cpu_stall`=0, `busy`=0, `done`=0.
- Reset mid-dump aborts immediately, with no final word and no `done`. `cpu_stall` releases the cycle after the reset edge.
- Edge numbering: E0 is the edge where `start` is sampled.
  - STALL after E0, READ after E1.
  - First `dump_valid` (index 0) is visible after E2.
- With `dump_ready` held high, each word costs 2 cycles:
  - Index k is valid after E(2+2k).
  - Index 31 is valid after E64, with `dump_last`=1.
  - `done` is high after E65.
  - IDLE after E66, with `cpu_stall` low.
- Backpressure adds one cycle per cycle that `dump_ready` is low in SEND. There is no other latency change.
- Simultaneous `start` and DONE→IDLE transition: `start` is ignored; it must be reasserted in IDLE.
- `dump_ready` while `dump_valid`=0 has no effect.

## Structure

- Shared package holds:
  - `NUM_REGS`, `DATA_W`, `IDX_W` defaults, also used by the register file.
  - The 3-bit state encoding localparams.
- Single module; no sub-module needed.
- `cpu` gains a `stall` input and a third read port. Both are wired at the top level, outside this block.

## Test plan

- Preload `regs[k]`=32'h1000_0000+k. Pulse `start` with `dump_ready`=1 → 32 words, index 0..31, data 0 then 32'h1000_0001..32'h1000_001F. `dump_last` only on index 31. `done` after E65.
- Hold `dump_ready`=0 for 5 cycles during index 7 → `dump_index`=7 and `dump_data` stable throughout; index 8 appears 2 cycles after the accepting edge.
- Assert `start` while busy at index 10 → no restart; sequence continues to 31 and exactly one `done`.
- Drop `rst_n` in SEND at index 12 → next cycle `dump_valid`=0, `cpu_stall`=0, `busy`=0, no `done`. A new `start` then begins again from index 0.
- Run `cpu` program writing `$t0`=32'hDEAD_BEEF and pulse `start` mid-program → `cpu_stall` freezes PC. Word index 8 = 32'hDEADBEEF. PC resumes from the same value after `done`.
- `start` during reset → ignored; IDLE after reset release with all outputs 0.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared sizes and state encoding for the register-dump sequencer
package regfile_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_STALL = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_SEND  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - valid/ready stream carrying {index, value} dump words
interface regfile_dump_if #(
  parameter int IDX_W  = regfile_dump_pkg::IDX_W,
  parameter int DATA_W = regfile_dump_pkg::DATA_W
);

  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_index;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    input  dump_ready,
    output dump_index,
    output dump_data,
    output dump_last
  );

  modport slave (
    input  dump_valid,
    output dump_ready,
    input  dump_index,
    input  dump_data,
    input  dump_last
  );

endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - stalls the CPU and streams every architectural register out
module regfile_dump #(
  parameter int NUM_REGS = regfile_dump_pkg::NUM_REGS,
  parameter int DATA_W   = regfile_dump_pkg::DATA_W,
  parameter int IDX_W    = regfile_dump_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cpu_stall,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  regfile_dump_if.master    dump,
  output logic              busy,
  output logic              done
);

  import regfile_dump_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  index_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              valid_c;
  logic              accept;

  assign accept = (state == ST_SEND) && dump.dump_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_STALL;
      // One dead cycle lets a writeback already in the pipe land before the first read.
      ST_STALL: state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_SEND;
      ST_SEND:  if (accept) state_nxt = last_q ? ST_DONE : ST_READ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_c   = 1'b0;
    busy      = 1'b1;
    cpu_stall = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        cpu_stall = 1'b0;
      end
      ST_SEND: valid_c = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

  // Word registers only load in READ, so they hold steady for the whole SEND wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      index_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        idx <= '0;
      end else if (accept && !last_q && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_READ) begin
        data_q  <= rf_rdata;
        index_q <= idx;
        last_q  <= (idx == LAST_IDX);
      end
    end
  end

  assign rf_raddr        = idx;
  assign dump.dump_valid = valid_c;
  assign dump.dump_index = index_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_q;

endmodule
